// File: rtl/baud_gen_frac.sv
// baud_gen_frac: fractional-divisor oversample/bit strobe generator; optional mid_tick_o via BAUD_GEN_FRAC_MID_EN
module baud_gen_frac #(
  parameter int DIV_W        = 16,
  parameter int FRAC_W       = 4,
  parameter int OVS          = 16,
  parameter int RST_DIV_INT  = 625,
  parameter int RST_DIV_FRAC = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    load_i,
  input  logic [DIV_W-1:0]        div_int_i,
  input  logic [FRAC_W-1:0]       div_frac_i,
  output logic                    os_tick_o,
  output logic                    bclk_o,
  output logic [$clog2(OVS)-1:0]  os_phase_o,
  output logic                    cfg_err_o
`ifdef BAUD_GEN_FRAC_MID_EN
  ,
  output logic                    mid_tick_o
`endif
);
  localparam int PW = $clog2(OVS);
  logic [DIV_W-1:0]  sh_int_q, sh_int_d, cnt_q, cnt_d, reload;
  logic [FRAC_W-1:0] sh_frac_q, sh_frac_d, acc_q, acc_d, acc_sum;
  logic [PW-1:0]     ph_q, ph_d;
  logic [DIV_W:0]    per;
  logic              tick_q, tick_d, bclk_q, bclk_d, err_q, err_d, carry, wrap, bad;
  // shadow capture, fractional period arithmetic and strobe decode
  always_comb begin
    bad       = div_int_i < DIV_W'(2);
    sh_int_d  = load_i ? (bad ? DIV_W'(2) : div_int_i) : sh_int_q;
    sh_frac_d = load_i ? div_frac_i : sh_frac_q;
    err_d     = load_i ? bad : err_q;
    {carry, acc_sum} = {1'b0, acc_q} + {1'b0, sh_frac_q};
    per       = {1'b0, sh_int_q} + {{DIV_W{1'b0}}, carry};
    reload    = per[DIV_W] ? '1 : per[DIV_W-1:0];
    wrap      = en_i && cnt_q == '0;
    cnt_d     = !en_i ? sh_int_q - DIV_W'(1) : wrap ? reload - DIV_W'(1) : cnt_q - DIV_W'(1);
    acc_d     = !en_i ? '0 : wrap ? acc_sum : acc_q;
    ph_d      = !en_i ? '0 : wrap ? ph_q + 1'b1 : ph_q;
    tick_d    = wrap;
    bclk_d    = wrap && ph_q == PW'(OVS - 1);
  end
  // state registers; reset restores power-on divisor and aborts the running period
  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_int_q  <= DIV_W'(RST_DIV_INT);
      sh_frac_q <= FRAC_W'(RST_DIV_FRAC);
      cnt_q     <= DIV_W'(RST_DIV_INT - 1);
      acc_q     <= '0;
      ph_q      <= '0;
      tick_q    <= 1'b0;
      bclk_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      sh_int_q  <= sh_int_d;
      sh_frac_q <= sh_frac_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      ph_q      <= ph_d;
      tick_q    <= tick_d;
      bclk_q    <= bclk_d;
      err_q     <= err_d;
    end
  end
  assign os_tick_o  = tick_q;
  assign bclk_o     = bclk_q;
  assign os_phase_o = ph_q;
  assign cfg_err_o  = err_q;
`ifdef BAUD_GEN_FRAC_MID_EN
  logic mid_q, mid_d;
  // bit-centre strobe on the os_tick that leaves phase OVS/2-1
  always_comb mid_d = wrap && ph_q == PW'(OVS / 2 - 1);
  // mid strobe register
  always_ff @(posedge clk) begin
    if (!rst) mid_q <= 1'b0;
    else mid_q <= mid_d;
  end
  assign mid_tick_o = mid_q;
`endif
endmodule

// File: doc/baud_gen_frac.md
Name: baud_gen_frac

Overview:
- Parametrised successor to the fixed integer baud generator.
- Produces a 1-cycle oversample strobe (os_tick) and a 1-cycle bit strobe (bclk, every OVS os_ticks) from one system clock.
- Divisor is integer plus fractional, using a phase accumulator to cut baud error. It is runtime-loadable through shadow registers and takes effect glitch-free.
- Feeds the UART TX shifter (bclk) and the RX oversampling sampler (os_tick).

Parameters:
- DIV_W, 16, width of integer divisor (clocks per os_tick).
- FRAC_W, 4, width of fractional divisor; fraction = div_frac / 2^FRAC_W.
- OVS, 16, os_ticks per bit; power of two, minimum 4.
- RST_DIV_INT, 625, integer divisor after reset (96 MHz / 9600 / 16).
- RST_DIV_FRAC, 0, fractional divisor after reset.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-low reset.
- en  in  1  run enable; low holds counters at start values.
- load  in  1  1-cycle pulse; captures div_int_in/div_frac_in into shadow.
- div_int_in  in  DIV_W  new integer divisor.
- div_frac_in  in  FRAC_W  new fractional divisor.
- os_tick  out  1  oversample strobe, 1 cycle.
- bclk  out  1  bit strobe, 1 cycle, coincident with every OVS-th os_tick.
- os_phase  out  log2(OVS)  current oversample index 0..OVS-1.
- cfg_err  out  1  sticky: last load had div_int_in < 2.

Behaviour:
- Reset (rst=0 at an edge):
  - Shadow set to RST_DIV_INT/RST_DIV_FRAC.
  - cnt = RST_DIV_INT-1; acc = 0; os_phase = 0.
  - os_tick, bclk and cfg_err = 0.
  - Reset overrides en and load, and aborts any period in progress.
- Period P = div_int + carry, where carry comes from the FRAC_W-bit accumulator.
- en=0:
  - cnt = shadow_int-1, acc = 0, os_phase = 0; os_tick and bclk = 0.
  - A load while en=0 is reflected in cnt on the next cycle.
- en=1, at each edge:
  - If cnt==0: os_tick<=1; {carry,acc}<=acc+shadow_frac; cnt<=shadow_int+carry-1; os_phase<=os_phase+1 (wraps OVS-1 to 0).
  - Otherwise: cnt<=cnt-1, os_tick<=0.
- Latency: with en sampled high at edge k, the first os_tick is registered at edge k+P0-1, where P0 = shadow_int. Subsequent os_ticks are spaced exactly P clocks.
- bclk<=1 on the same edge as os_tick when os_phase==OVS-1 before the increment. bclk is never high without os_tick.
- Load:
  - Shadow updates on the edge after load=1.
  - The running period is never truncated; the new value applies from the next reload.
  - Load coincident with a reload edge: that reload uses the old shadow; the new value applies from the following reload.
  - acc is not cleared by load.
- Minimum divisor: div_int_in < 2 loads shadow_int = 2 and sets cfg_err=1. A later valid load clears cfg_err. Only reset or a valid load clears it.
- en falling mid-period: counters are restored to start values on the next edge. There is no partial strobe.
- Widths:
  - Counter is DIV_W bits.
  - shadow_int + carry must not overflow. shadow_int = 2^DIV_W-1 with carry is saturated to 2^DIV_W-1.

Optional Feature:
- Macro BAUD_GEN_FRAC_MID_EN.
- Defined: adds output mid_tick (1 bit). It is asserted with os_tick when os_phase==OVS/2-1 before the increment (bit-centre sample strobe for RX). It resets to 0 and is 0 while en=0.
- Undefined: no mid_tick port; all other behaviour is identical.

Test Plan:
- Reset: rst=0 for 2 cycles with en=1 -> os_tick=bclk=cfg_err=0, os_phase=0. After rst=1 with defaults, os_tick is spaced 625 clocks and bclk is spaced 10000 clocks.
- Fractional: load div_int_in=10, div_frac_in=8, en=1 -> first period 10; interval spanning 32 consecutive periods after the first os_tick = 336 clocks; periods alternate 10/11.
- Reload on the fly: running div 625, load div_int_in=100 mid-period -> current period completes at 625; the next period is 100 (or 625 then 100 if load hits the reload edge).
- Min clamp: load div_int_in=1 -> os_tick every 2 clocks, cfg_err=1. Then load 50 -> cfg_err=0, period 50.
- Enable gating: drop en mid-period, re-raise after 5 cycles -> no strobe while low; first os_tick P cycles later; os_phase restarts at 0; bclk after OVS os_ticks.
- With BAUD_GEN_FRAC_MID_EN, div 20, OVS 16 -> mid_tick once per bit, 8 os_ticks (160 clocks) before each bclk.
